// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: default reset PC, NOP control word,
// ID/EX control-word layout and the per-edge stage operation decode.
package pipe_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam int unsigned IDEX_CTRL_W = 8;
    localparam logic [IDEX_CTRL_W-1:0] CTRL_NOP = '0;

    // Bit positions of the ID/EX control word, for instantiators packing in_ctrl.
    localparam int unsigned CTRL_MEMWR_BIT    = 0;
    localparam int unsigned CTRL_MEMRD_BIT    = 1;
    localparam int unsigned CTRL_REGWR_BIT    = 2;
    localparam int unsigned CTRL_REGDST_BIT   = 3;
    localparam int unsigned CTRL_MEMTOREG_BIT = 4;
    localparam int unsigned CTRL_ALUFUN_LSB   = 5;
    localparam int unsigned CTRL_ALUFUN_W     = 2;
    localparam int unsigned CTRL_JAL_BIT      = 7;

    typedef struct packed {
        logic       jal;
        logic [1:0] alu_fun;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
    } idex_ctrl_t;

    typedef enum logic [1:0] {
        OP_LOAD   = 2'd0,
        OP_BUBBLE = 2'd1,
        OP_HOLD   = 2'd2,
        OP_FLUSH  = 2'd3
    } stage_op_e;

    // Resolves the control inputs to one operation: flush > hold > bubble > load.
    function automatic stage_op_e stage_op(input logic flush, input logic hold, input logic bubble);
        stage_op_e op;
        op = OP_LOAD;
        if (flush) begin
            op = OP_FLUSH;
        end else if (hold) begin
            op = OP_HOLD;
        end else if (bubble) begin
            op = OP_BUBBLE;
        end
        return op;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer: catches an upstream transfer that lands while the
// stage is held, and hands it back once the stage can advance again.
module pipe_skid_buf #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [31:0]       i_pc,
    output logic              o_full,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [31:0]       o_pc
);

    logic              r_full;
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_pc;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_full  <= 1'b0;
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_pc    <= '0;
        end else if (i_push && !r_full) begin
            r_full  <= 1'b1;
            r_valid <= i_valid;
            r_ctrl  <= i_ctrl;
            r_data  <= i_data;
            r_pc    <= i_pc;
        end else if (i_pop) begin
            r_full  <= 1'b0;
            r_valid <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;
    assign o_pc    = r_pc;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with hold, bubble, flush, optional skid entry
// and a saturating bubble counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = 8,
    parameter int unsigned DATA_W   = 96,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter bit          SKID     = 1'b0,
    parameter int unsigned STAT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    output logic              in_ready,
    input  logic              hold,
    input  logic              bubble,
    input  logic              flush,
    output logic              out_valid,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] bubble_cnt
);

    stage_op_e         w_op;
    logic              w_skid_full;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [31:0]       w_skid_pc;

    logic              w_src_valid;
    logic [CTRL_W-1:0] w_src_ctrl;
    logic [DATA_W-1:0] w_src_data;
    logic [31:0]       w_src_pc;

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [31:0]       r_pc;
    logic [STAT_W-1:0] r_bubble_cnt;

    assign w_op = stage_op(flush, hold, bubble);

    generate
        if (SKID) begin : g_skid
            logic w_push;
            logic w_pop;

            assign w_push = (w_op == OP_HOLD) && in_valid && !w_skid_full;
            assign w_pop  = (w_op == OP_LOAD) || (w_op == OP_BUBBLE);

            pipe_skid_buf #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_clear (w_op == OP_FLUSH),
                .i_push  (w_push),
                .i_pop   (w_pop),
                .i_valid (in_valid),
                .i_ctrl  (in_ctrl),
                .i_data  (in_data),
                .i_pc    (in_pc),
                .o_full  (w_skid_full),
                .o_valid (w_skid_valid),
                .o_ctrl  (w_skid_ctrl),
                .o_data  (w_skid_data),
                .o_pc    (w_skid_pc)
            );

            // Ready comes straight from the skid flag flop, so upstream sees no comb path.
            assign in_ready = !w_skid_full;
        end else begin : g_no_skid
            assign w_skid_full  = 1'b0;
            assign w_skid_valid = 1'b0;
            assign w_skid_ctrl  = '0;
            assign w_skid_data  = '0;
            assign w_skid_pc    = '0;
            assign in_ready     = !hold;
        end
    endgenerate

    // A full skid entry is older than anything on in_*, so it always goes first.
    assign w_src_valid = w_skid_full ? w_skid_valid : in_valid;
    assign w_src_ctrl  = w_skid_full ? w_skid_ctrl  : in_ctrl;
    assign w_src_data  = w_skid_full ? w_skid_data  : in_data;
    assign w_src_pc    = w_skid_full ? w_skid_pc    : in_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
            r_pc    <= RESET_PC;
        end else begin
            case (w_op)
                OP_FLUSH: begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_pc    <= RESET_PC;
                end
                OP_HOLD: begin
                end
                OP_BUBBLE: begin
                    r_valid <= 1'b0;
                    r_ctrl  <= '0;
                    r_data  <= w_src_data;
                    r_pc    <= w_src_pc;
                end
                default: begin
                    r_valid <= w_src_valid;
                    r_ctrl  <= w_src_valid ? w_src_ctrl : '0;
                    r_data  <= w_src_data;
                    r_pc    <= w_src_pc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr_stats) begin
            r_bubble_cnt <= '0;
        end else if ((w_op == OP_BUBBLE) && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    assign out_valid  = r_valid;
    assign out_ctrl   = r_ctrl;
    assign out_data   = r_data;
    assign out_pc     = r_pc;
    assign bubble_cnt = r_bubble_cnt;

endmodule
